// File: rtl/adder_pkg.sv
// Shared definitions for the adder and its stream controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the controller state encoding and the default operand and counter
// widths so the adder instance, the controller and their benches agree.
package adder_pkg;

  // Controller state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_EVAL = S_EVAL,
    ST_OUT  = S_OUT
  } ctrl_state_t;

  // Default widths.
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/adder_stream_ctrl.sv
// Registered valid/ready front/back end around a combinational adder.
// Latency: accept edge t -> out_valid high after edge t+1; 3 cycles min per txn.
// Backpressure: in_ready high only in IDLE; result held in OUT until out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand stream handshake; in_a/in_b operands
//   add_a/add_b         registered operands driven to the adder instance
//   add_sum             adder sum, combinational from add_a/add_b
//   out_valid/out_ready result stream handshake; out_sum/out_carry result
//   txn_count           completed output handshakes, wraps at 2^CNT_W
module adder_stream_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] txn_count
);

  ctrl_state_t state;

  // All outputs are registered; in_ready is held as a flop that mirrors
  // "state == IDLE" so downstream timing sees a clean register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      add_a     <= '0;
      add_b     <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_valid <= 1'b0;
      txn_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            add_a    <= in_a;
            add_b    <= in_b;
            in_ready <= 1'b0;
            state    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // The adder has had a full cycle to settle on add_a/add_b.
          // A modular sum smaller than an operand means it wrapped.
          out_sum   <= add_sum;
          out_carry <= (add_sum < add_a);
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            txn_count <= txn_count + 1'b1;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Directed bench for adder_stream_ctrl with a behavioural adder beside it.
module tb_adder_stream_ctrl;
  import adder_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int C = DEF_CNT_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_sum;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic [C-1:0] txn_count;

  int           checks = 0;
  int           errors = 0;
  logic [C-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational adder instance.
  assign add_sum = add_a + add_b;

  adder_stream_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .txn_count (txn_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready held high: IDLE -> EVAL -> OUT -> IDLE.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic ec);
    chk("pre_in_ready", in_ready, 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    tick();
    in_valid = 1'b0;
    chk("acc_add_a", add_a, a);
    chk("acc_add_b", add_b, b);
    chk("eval_in_ready", in_ready, 0);
    chk("eval_out_valid", out_valid, 0);
    tick();
    chk("out_valid", out_valid, 1);
    chk("out_sum", out_sum, es);
    chk("out_carry", out_carry, ec);
    chk("out_in_ready", in_ready, 0);
    tick();
    exp_cnt++;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_txn_count", txn_count, exp_cnt);
  endtask

  initial begin
    logic [W:0]   full;
    logic [W-1:0] cap_sum;
    logic         cap_carry;
    logic         got;
    int           n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state.
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    // Basic transaction, then two carry cases.
    do_txn(4'd3, 4'd4, 4'd7, 1'b0);
    do_txn(4'd15, 4'd1, 4'd0, 1'b1);
    do_txn(4'd9, 4'd9, 4'd2, 1'b1);

    // Stall in OUT while the input side toggles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 4'd5;
    in_b      = 4'd6;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_a     = 4'($urandom);
      in_b     = 4'($urandom);
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_sum", out_sum, 11);
      chk("stall_out_carry", out_carry, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_add_a", add_a, 5);
      chk("stall_add_b", add_b, 6);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("stall_hs_valid", out_valid, 0);
    chk("stall_hs_count", txn_count, exp_cnt);
    tick();
    chk("stall_idle_count", txn_count, exp_cnt);

    // Reset during EVAL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 4'd7;
    in_b      = 4'd8;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rste_out_valid", out_valid, 0);
    chk("rste_out_sum", out_sum, 0);
    chk("rste_out_carry", out_carry, 0);
    chk("rste_txn_count", txn_count, 0);
    chk("rste_add_a", add_a, 0);
    rst_n   = 1'b1;
    exp_cnt = '0;
    tick();
    chk("rste_in_ready", in_ready, 1);

    // Reset during OUT.
    in_valid = 1'b1;
    in_a     = 4'd9;
    in_b     = 4'd9;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rsto_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rsto_out_valid", out_valid, 0);
    chk("rsto_out_sum", out_sum, 0);
    chk("rsto_out_carry", out_carry, 0);
    rst_n = 1'b1;
    tick();
    chk("rsto_in_ready", in_ready, 1);
    do_txn(4'd2, 4'd2, 4'd4, 1'b0);

    // Fresh reset so the sweep starts the counter at zero.
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    exp_cnt = '0;
    tick();

    // Exhaustive sweep with random output stalls.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        full = 5'(a) + 5'(b);
        chk("sw_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_a     = 4'(a);
        in_b     = 4'(b);
        tick();
        in_valid  = 1'b0;
        got       = 1'b0;
        n         = 0;
        cap_sum   = '0;
        cap_carry = 1'b0;
        while (!got && n < 40) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            cap_sum   = out_sum;
            cap_carry = out_carry;
            got       = 1'b1;
          end
          tick();
          n++;
        end
        chk("sw_handshake", got, 1);
        exp_cnt++;
        chk("sw_sum", cap_sum, full[W-1:0]);
        chk("sw_carry", cap_carry, full[W]);
        chk("sw_count", txn_count, exp_cnt);
        chk("sw_valid_drop", out_valid, 0);
      end
    end
    chk("sw_wrap", txn_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
